cnn_mem_responder: RTL and testbench

//  Synthesizable memory responder (slave) that serves both the picorv32 native memory

---
 rtl/cnn_mem_pkg.sv | 8 +
 rtl/cnn_mem_responder_rr_arb2.sv | 22 ++
 rtl/cnn_mem_responder.sv | 123 ++++++++++++
 tb/tb_cnn_mem_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cnn_mem_pkg.sv
// cnn_mem_pkg: shared FSM states, port ids and MMIO constants for the memory responder
package cnn_mem_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;
  typedef enum logic {PORT_CPU = 1'b0, PORT_ACC = 1'b1} port_e;
  localparam logic [31:0] CONSOLE_ADDR = 32'h1000_0000;
  localparam logic [31:0] PASS_ADDR    = 32'h2000_0000;
  localparam logic [31:0] PASS_MAGIC   = 32'd123456789;
endpackage

// File: rtl/cnn_mem_responder_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, the port that did not win last time wins a tie
module rr_arb2
  import cnn_mem_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       advance,
  output port_e      grant
);
  port_e last_q, last_d;
  // grant selection and last-winner update on each accepted grant
  always_comb begin
    grant  = (req == 2'b11) ? ((last_q == PORT_CPU) ? PORT_ACC : PORT_CPU) : port_e'(req[1]);
    last_d = advance ? grant : last_q;
  end
  // last-winner register, ACC after reset so CPU wins the first tie
  always_ff @(posedge clk) begin
    if (!resetn) last_q <= PORT_ACC;
    else         last_q <= last_d;
  end
endmodule

// File: rtl/cnn_mem_responder.sv
// cnn_mem_responder: serves CPU and accelerator memory ports from one single-port sync RAM
module cnn_mem_responder
  import cnn_mem_pkg::*;
#(
  parameter int MEM_WORDS = 3145728,
  parameter int AW        = 22
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cpu_mem_valid,
  input  logic [31:0]   cpu_mem_addr,
  input  logic [31:0]   cpu_mem_wdata,
  input  logic [3:0]    cpu_mem_wstrb,
  output logic          cpu_mem_ready,
  output logic [31:0]   cpu_mem_rdata,
  input  logic          acc_mem_valid,
  input  logic          acc_mem_write,
  input  logic [31:0]   acc_mem_addr,
  input  logic [31:0]   acc_mem_wdata,
  output logic          acc_mem_ready,
  output logic [31:0]   acc_mem_rdata,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic          console_valid,
  output logic [7:0]    console_data,
  output logic          tests_passed,
  output logic          oob_error,
  output logic [31:0]   oob_addr
);
  state_e      state_q, state_d;
  port_e       id_q, id_d, grant;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, oob_addr_q, oob_addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        tests_passed_q, tests_passed_d, oob_error_q, oob_error_d;
  logic        req_any, in_access, in_resp, in_ram, is_wr, cpu_mmio, ram_rd;
  logic [31:0] word;

  assign req_any   = cpu_mem_valid | acc_mem_valid;
  assign in_access = state_q == ST_ACCESS;
  assign in_resp   = state_q == ST_RESP;
  assign word      = {addr_q[31:2], 2'b00};
  assign in_ram    = {2'b00, addr_q[31:2]} < 32'(MEM_WORDS);
  assign is_wr     = |wstrb_q;
  assign cpu_mmio  = id_q == PORT_CPU && (word == CONSOLE_ADDR || word == PASS_ADDR);
  assign ram_rd    = in_ram && !is_wr;

  rr_arb2 u_arb (
    .clk     (clk),
    .resetn  (resetn),
    .req     ({acc_mem_valid, cpu_mem_valid}),
    .advance (state_q == ST_IDLE && req_any),
    .grant   (grant)
  );

  // request latch, FSM sequencing and sticky flag updates
  always_comb begin
    state_d        = state_q;
    id_d           = id_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    tests_passed_d = tests_passed_q | (in_access && cpu_mmio && is_wr && word == PASS_ADDR && wdata_q == PASS_MAGIC);
    oob_error_d    = oob_error_q;
    oob_addr_d     = oob_addr_q;
    case (state_q)
      ST_IDLE: if (req_any) begin
        state_d = ST_ACCESS;
        id_d    = grant;
        addr_d  = (grant == PORT_ACC) ? acc_mem_addr : cpu_mem_addr;
        wdata_d = (grant == PORT_ACC) ? acc_mem_wdata : cpu_mem_wdata;
        wstrb_d = (grant == PORT_ACC) ? {4{acc_mem_write}} : cpu_mem_wstrb;
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (!in_ram && !cpu_mmio && !oob_error_q) begin
          oob_error_d = 1'b1;
          oob_addr_d  = addr_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and request registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      id_q           <= PORT_CPU;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      tests_passed_q <= 1'b0;
      oob_error_q    <= 1'b0;
      oob_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      id_q           <= id_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      tests_passed_q <= tests_passed_d;
      oob_error_q    <= oob_error_d;
      oob_addr_q     <= oob_addr_d;
    end
  end

  assign ram_en        = in_access && in_ram;
  assign ram_we        = ram_en ? wstrb_q : 4'h0;
  assign ram_addr      = ram_en ? addr_q[AW+1:2] : '0;
  assign ram_wdata     = ram_en ? wdata_q : '0;
  assign console_valid = in_access && cpu_mmio && is_wr && word == CONSOLE_ADDR;
  assign console_data  = console_valid ? wdata_q[7:0] : 8'h00;
  assign cpu_mem_ready = in_resp && id_q == PORT_CPU;
  assign acc_mem_ready = in_resp && id_q == PORT_ACC;
  assign cpu_mem_rdata = (cpu_mem_ready && ram_rd) ? ram_rdata : '0;
  assign acc_mem_rdata = (acc_mem_ready && ram_rd) ? ram_rdata : '0;
  assign tests_passed  = tests_passed_q;
  assign oob_error     = oob_error_q;
  assign oob_addr      = oob_addr_q;
endmodule

// File: tb/tb_cnn_mem_responder.sv
// tb_cnn_mem_responder: directed table-driven checks of the dual-port memory responder
module tb_cnn_mem_responder;
  logic        clk = 1'b0, resetn = 1'b0;
  logic        cpu_mem_valid = 1'b0, acc_mem_valid = 1'b0, acc_mem_write = 1'b0;
  logic [31:0] cpu_mem_addr = '0, cpu_mem_wdata = '0, acc_mem_addr = '0, acc_mem_wdata = '0;
  logic [3:0]  cpu_mem_wstrb = '0;
  logic        cpu_mem_ready, acc_mem_ready, ram_en, console_valid, tests_passed, oob_error;
  logic [31:0] cpu_mem_rdata, acc_mem_rdata, ram_wdata, oob_addr;
  logic [31:0] ram_rdata = '0;
  logic [3:0]  ram_we;
  logic [21:0] ram_addr;
  logic [7:0]  console_data;

  cnn_mem_responder dut (
    .clk(clk), .resetn(resetn),
    .cpu_mem_valid(cpu_mem_valid), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_ready(cpu_mem_ready), .cpu_mem_rdata(cpu_mem_rdata),
    .acc_mem_valid(acc_mem_valid), .acc_mem_write(acc_mem_write), .acc_mem_addr(acc_mem_addr),
    .acc_mem_wdata(acc_mem_wdata), .acc_mem_ready(acc_mem_ready), .acc_mem_rdata(acc_mem_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .console_valid(console_valid), .console_data(console_data), .tests_passed(tests_passed),
    .oob_error(oob_error), .oob_addr(oob_addr)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [logic [21:0]];
  always @(posedge clk) begin
    if (ram_en) begin
      logic [31:0] w;
      w = mem.exists(ram_addr) ? mem[ram_addr] : 32'h0;
      ram_rdata <= w;
      for (int b = 0; b < 4; b++) if (ram_we[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
      if (|ram_we) mem[ram_addr] = w;
    end
  end

  int en_cnt = 0, cons_cnt = 0, cpu_rdy = 0, acc_rdy = 0, stray = 0;
  logic [3:0]  last_we = '0;
  logic [21:0] last_ra = '0;
  logic [7:0]  last_cd = '0;
  always @(negedge clk) begin
    if (ram_en) begin en_cnt++; last_we = ram_we; last_ra = ram_addr; end
    if (console_valid) begin cons_cnt++; last_cd = console_data; end
    if (cpu_mem_ready) cpu_rdy++;
    if (acc_mem_ready) acc_rdy++;
    if ((!cpu_mem_ready && cpu_mem_rdata != 0) || (!acc_mem_ready && acc_mem_rdata != 0) || (!ram_en && ram_we != 0)) stray++;
  end

  int checks = 0, errors = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic acc, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, output logic [31:0] rd, output int lat);
    lat = 0;
    rd  = '0;
    if (acc) begin
      acc_mem_valid = 1'b1; acc_mem_write = |wstrb; acc_mem_addr = addr; acc_mem_wdata = wdata;
    end else begin
      cpu_mem_valid = 1'b1; cpu_mem_wstrb = wstrb; cpu_mem_addr = addr; cpu_mem_wdata = wdata;
    end
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (acc ? acc_mem_ready : cpu_mem_ready) begin
        lat = k;
        rd  = acc ? acc_mem_rdata : cpu_mem_rdata;
        break;
      end
    end
    cpu_mem_valid = 1'b0;
    acc_mem_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic both_reads(output int cpu_at, output int acc_at);
    cpu_at = 0; acc_at = 0;
    cpu_mem_valid = 1'b1; cpu_mem_wstrb = 4'h0; cpu_mem_addr = 32'h0000_0400;
    acc_mem_valid = 1'b1; acc_mem_write = 1'b0; acc_mem_addr = 32'h0000_0404;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (cpu_mem_ready && cpu_at == 0) begin cpu_at = k; cpu_mem_valid = 1'b0; end
      if (acc_mem_ready && acc_at == 0) begin acc_at = k; acc_mem_valid = 1'b0; end
      if (cpu_at != 0 && acc_at != 0) break;
    end
    cpu_mem_valid = 1'b0;
    acc_mem_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        acc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rd;
    int          exp_en;
    logic [3:0]  exp_we;
    logic [21:0] exp_ra;
    int          exp_cons;
    logic [7:0]  exp_cd;
    logic        exp_pass;
    logic        exp_oob;
    logic [31:0] exp_oaddr;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int ca, aa, lat, e0, c0, cr0, ar0;
    logic [31:0] rd;
    tbl[0]  = '{0, 32'h0000_0100, 32'hDEADBEEF, 4'hF, 32'h0,        1, 4'hF, 22'h40,     0, 8'h00, 0, 0, 32'h0};
    tbl[1]  = '{0, 32'h0000_0100, 32'h0,        4'h0, 32'hDEADBEEF, 1, 4'h0, 22'h40,     0, 8'h00, 0, 0, 32'h0};
    tbl[2]  = '{0, 32'h0000_0200, 32'h11223344, 4'hF, 32'h0,        1, 4'hF, 22'h80,     0, 8'h00, 0, 0, 32'h0};
    tbl[3]  = '{0, 32'h0000_0200, 32'h0000AB00, 4'h2, 32'h0,        1, 4'h2, 22'h80,     0, 8'h00, 0, 0, 32'h0};
    tbl[4]  = '{0, 32'h0000_0200, 32'h0,        4'h0, 32'h1122AB44, 1, 4'h0, 22'h80,     0, 8'h00, 0, 0, 32'h0};
    tbl[5]  = '{1, 32'h0000_0300, 32'hCAFEF00D, 4'hF, 32'h0,        1, 4'hF, 22'hC0,     0, 8'h00, 0, 0, 32'h0};
    tbl[6]  = '{1, 32'h0000_0300, 32'h0,        4'h0, 32'hCAFEF00D, 1, 4'h0, 22'hC0,     0, 8'h00, 0, 0, 32'h0};
    tbl[7]  = '{0, 32'h0000_0102, 32'h0,        4'h0, 32'hDEADBEEF, 1, 4'h0, 22'h40,     0, 8'h00, 0, 0, 32'h0};
    tbl[8]  = '{1, 32'h00BF_FFFC, 32'h5A5A5A5A, 4'hF, 32'h0,        1, 4'hF, 22'h2FFFFF, 0, 8'h00, 0, 0, 32'h0};
    tbl[9]  = '{0, 32'h00BF_FFFC, 32'h0,        4'h0, 32'h5A5A5A5A, 1, 4'h0, 22'h2FFFFF, 0, 8'h00, 0, 0, 32'h0};
    tbl[10] = '{0, 32'h1000_0000, 32'h0000_0041, 4'h1, 32'h0,       0, 4'h0, 22'h0,      1, 8'h41, 0, 0, 32'h0};
    tbl[11] = '{0, 32'h1000_0000, 32'h0,        4'h0, 32'h0,        0, 4'h0, 22'h0,      0, 8'h00, 0, 0, 32'h0};
    tbl[12] = '{0, 32'h2000_0000, 32'd12345,    4'hF, 32'h0,        0, 4'h0, 22'h0,      0, 8'h00, 0, 0, 32'h0};
    tbl[13] = '{0, 32'h2000_0000, 32'd123456789, 4'hF, 32'h0,       0, 4'h0, 22'h0,      0, 8'h00, 1, 0, 32'h0};
    tbl[14] = '{1, 32'h00C0_0000, 32'h0,        4'h0, 32'h0,        0, 4'h0, 22'h0,      0, 8'h00, 1, 1, 32'h00C0_0000};
    tbl[15] = '{1, 32'h1000_0000, 32'h0000_0042, 4'hF, 32'h0,       0, 4'h0, 22'h0,      0, 8'h00, 1, 1, 32'h00C0_0000};
    tbl[16] = '{0, 32'h00C0_0004, 32'h12345678, 4'hF, 32'h0,        0, 4'h0, 22'h0,      0, 8'h00, 1, 1, 32'h00C0_0000};

    repeat (2) @(posedge clk);
    #1;
    check("reset_strobes", {26'h0, cpu_mem_ready, acc_mem_ready, ram_en, console_valid, tests_passed, oob_error}, 32'h0);
    check("reset_ram_we", {28'h0, ram_we}, 32'h0);
    check("reset_rdata", cpu_mem_rdata | acc_mem_rdata, 32'h0);
    check("reset_oob_addr", oob_addr, 32'h0);

    resetn = 1'b1;
    both_reads(ca, aa);
    check("arb1_cpu_at", ca, 2);
    check("arb1_acc_at", aa, 5);
    xfer(1'b0, 32'h0000_0408, 32'h0, 4'h0, rd, lat);
    check("arb_single_lat", lat, 2);
    both_reads(ca, aa);
    check("arb2_acc_at", aa, 2);
    check("arb2_cpu_at", ca, 5);

    foreach (tbl[i]) begin
      e0 = en_cnt; c0 = cons_cnt; cr0 = cpu_rdy; ar0 = acc_rdy;
      xfer(tbl[i].acc, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, rd, lat);
      check($sformatf("v%0d_latency", i), lat, 2);
      check($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("v%0d_ram_en_cycles", i), en_cnt - e0, tbl[i].exp_en);
      if (tbl[i].exp_en != 0) begin
        check($sformatf("v%0d_ram_we", i), {28'h0, last_we}, {28'h0, tbl[i].exp_we});
        check($sformatf("v%0d_ram_addr", i), {10'h0, last_ra}, {10'h0, tbl[i].exp_ra});
      end
      check($sformatf("v%0d_console_pulses", i), cons_cnt - c0, tbl[i].exp_cons);
      if (tbl[i].exp_cons != 0) check($sformatf("v%0d_console_data", i), {24'h0, last_cd}, {24'h0, tbl[i].exp_cd});
      check($sformatf("v%0d_other_ready", i), tbl[i].acc ? cpu_rdy - cr0 : acc_rdy - ar0, 0);
      check($sformatf("v%0d_tests_passed", i), {31'h0, tests_passed}, {31'h0, tbl[i].exp_pass});
      check($sformatf("v%0d_oob_error", i), {31'h0, oob_error}, {31'h0, tbl[i].exp_oob});
      check($sformatf("v%0d_oob_addr", i), oob_addr, tbl[i].exp_oaddr);
    end

    cpu_mem_valid = 1'b1; cpu_mem_wstrb = 4'h0; cpu_mem_addr = 32'h0000_0100;
    @(posedge clk); #1;
    check("rst_mid_in_access", {31'h0, ram_en}, 32'h1);
    cr0 = cpu_rdy;
    resetn = 1'b0;
    cpu_mem_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_strobes", {26'h0, cpu_mem_ready, acc_mem_ready, ram_en, console_valid, tests_passed, oob_error}, 32'h0);
    check("rst_mid_oob_addr", oob_addr, 32'h0);
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_no_ready", cpu_rdy - cr0, 0);
    check("stray_outputs", stray, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
